// File: rtl/clock_time_counter.sv
// -----------------------------------------------------------------------------
// clock_time_counter
//
// Keeps MM:SS time as four BCD digits. The time advances on the 1 Hz tick
// while running. It can be paused, cleared, or adjusted one field at a time at
// the 2 Hz rate. While a field is being adjusted, that field blinks.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   tick_1hz    1-cycle count enable (RUN mode)
//   tick_2hz    1-cycle adjust-rate enable (ADJ mode)
//   tick_blink  1-cycle blink-phase toggle (ADJ mode)
//   adj         level, 1 = adjust mode
//   sel         level, used only in adjust mode: 0 = minutes, 1 = seconds
//   pause_p     1-cycle pulse, toggles the paused flag
//   clr_p       1-cycle pulse, time -> 00:00 (paused flag untouched)
//   min_tens/min_ones/sec_tens/sec_ones  BCD time digits
//   blank_min/blank_sec                  blank requests for the scan driver
//   paused                               current paused flag
//
// Every output is registered and reflects the inputs sampled on the same edge.
// -----------------------------------------------------------------------------
module clock_time_counter #(
  parameter int unsigned MIN_MODULO   = 60,   // minutes count 0..MIN_MODULO-1 (2..100)
  parameter logic        RESET_PAUSED = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
  input  logic       adj,
  input  logic       sel,
  input  logic       pause_p,
  input  logic       clr_p,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       paused
);

  // Last legal value of each field, split into BCD digits so the wrap test
  // works on the full two-digit value.
  localparam int unsigned MIN_LAST      = MIN_MODULO - 1;
  localparam logic [3:0]  MIN_LAST_TENS = 4'(MIN_LAST / 10);
  localparam logic [3:0]  MIN_LAST_ONES = 4'(MIN_LAST % 10);
  localparam logic [3:0]  SEC_LAST_TENS = 4'd5;
  localparam logic [3:0]  SEC_LAST_ONES = 4'd9;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_PAUSE,
    MODE_ADJ
  } mode_t;

  // One step of a two-digit BCD field: returns {tens, ones}.
  // A field sitting at its last value wraps to 00; otherwise ones 9 -> 0
  // carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                         input logic [3:0] ones,
                                         input logic       at_last);
    logic [7:0] res;
    if (at_last) begin
      res = 8'h00;
    end else if (ones == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

  // State registers
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       paused_q,   paused_d;
  logic       phase_q,    phase_d;
  logic       blank_min_q, blank_min_d;
  logic       blank_sec_q, blank_sec_d;

  mode_t      mode;
  logic       sec_at_last;
  logic       min_at_last;
  logic [7:0] sec_inc;
  logic [7:0] min_inc;

  // Mode is decoded from the live adj level and the stored paused flag, so a
  // change of adj acts in the cycle it is sampled, and a pause_p arriving with
  // a tick only affects later ticks.
  always_comb begin
    if (adj) begin
      mode = MODE_ADJ;
    end else if (paused_q) begin
      mode = MODE_PAUSE;
    end else begin
      mode = MODE_RUN;
    end
  end

  always_comb begin
    sec_at_last = (sec_tens_q == SEC_LAST_TENS) && (sec_ones_q == SEC_LAST_ONES);
    min_at_last = (min_tens_q == MIN_LAST_TENS) && (min_ones_q == MIN_LAST_ONES);
    sec_inc     = bcd_inc(sec_tens_q, sec_ones_q, sec_at_last);
    min_inc     = bcd_inc(min_tens_q, min_ones_q, min_at_last);
  end

  // Next-state logic for time, paused flag and blink phase.
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;

    if (clr_p) begin
      // Clear wins over any tick in the same cycle.
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else begin
      case (mode)
        MODE_RUN: begin
          if (tick_1hz) begin
            {sec_tens_d, sec_ones_d} = sec_inc;
            // Seconds wrapping 59 -> 00 carries into minutes.
            if (sec_at_last) begin
              {min_tens_d, min_ones_d} = min_inc;
            end
          end
        end
        MODE_ADJ: begin
          // Adjusting never carries into the other field.
          if (tick_2hz) begin
            if (sel) begin
              {sec_tens_d, sec_ones_d} = sec_inc;
            end else begin
              {min_tens_d, min_ones_d} = min_inc;
            end
          end
        end
        MODE_PAUSE: begin
        end
        default: begin
        end
      endcase
    end

    paused_d = paused_q ^ pause_p;

    // Phase only runs in adjust mode, so blinking always starts from "shown".
    phase_d = adj ? (phase_q ^ tick_blink) : 1'b0;

    blank_min_d = adj & ~sel & phase_d;
    blank_sec_d = adj &  sel & phase_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
      paused_q    <= RESET_PAUSED;
      phase_q     <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      paused_q    <= paused_d;
      phase_q     <= phase_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// -----------------------------------------------------------------------------
// tb_clock_time_counter
//
// Table of hand-derived vectors, directed multi-cycle sequences (minute carry,
// hour wrap, adjust wrap, clear priority) and a randomized run. Every cycle is
// also compared against a reference model that tracks the time as integer
// minutes/seconds.
// Input vectors are packed as {rst, tick_1hz, tick_2hz, tick_blink, adj, sel,
// pause_p, clr_p}; expected flags as {paused, blank_min, blank_sec}.
// -----------------------------------------------------------------------------
module tb_clock_time_counter;

  localparam int MIN_MODULO = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       tick_blink = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       pause_p = 1'b0;
  logic       clr_p = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       blank_min, blank_sec, paused;

  always #5 clk = ~clk;

  clock_time_counter #(
    .MIN_MODULO  (MIN_MODULO),
    .RESET_PAUSED(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .tick_blink(tick_blink),
    .adj       (adj),
    .sel       (sel),
    .pause_p   (pause_p),
    .clr_p     (clr_p),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .blank_min (blank_min),
    .blank_sec (blank_sec),
    .paused    (paused)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time as plain integers.
  int m_min = 0;
  int m_sec = 0;
  bit m_paused = 1'b0;
  bit m_phase = 1'b0;
  bit m_bmin = 1'b0;
  bit m_bsec = 1'b0;

  typedef struct {
    logic [7:0] in;
    int         e_min;
    int         e_sec;
    logic [2:0] e_f;
  } vec_t;

  vec_t vecs[$];

  task automatic model_update(input logic [7:0] v);
    int total;
    if (v[7]) begin
      m_min = 0; m_sec = 0; m_paused = 1'b1; m_phase = 1'b0;
      m_bmin = 1'b0; m_bsec = 1'b0;
    end else begin
      if (v[0]) begin
        m_min = 0; m_sec = 0;
      end else if (v[3]) begin
        if (v[5]) begin
          if (v[2]) m_sec = (m_sec + 1) % 60;
          else      m_min = (m_min + 1) % MIN_MODULO;
        end
      end else if (!m_paused && v[6]) begin
        total = (m_min * 60 + m_sec + 1) % (MIN_MODULO * 60);
        m_min = total / 60;
        m_sec = total % 60;
      end
      m_paused = m_paused ^ v[1];
      m_phase  = v[3] ? (m_phase ^ v[4]) : 1'b0;
      m_bmin   = v[3] & ~v[2] & m_phase;
      m_bsec   = v[3] &  v[2] & m_phase;
    end
  endtask

  task automatic check(input string name, input int e_min, input int e_sec,
                       input logic e_p, input logic e_bm, input logic e_bs);
    logic [18:0] got;
    logic [18:0] exp;
    got = {min_tens, min_ones, sec_tens, sec_ones, paused, blank_min, blank_sec};
    exp = {4'(e_min / 10), 4'(e_min % 10), 4'(e_sec / 10), 4'(e_sec % 10), e_p, e_bm, e_bs};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h%0h:%0h%0h p=%0b bm=%0b bs=%0b, expected %02d:%02d p=%0b bm=%0b bs=%0b",
               name, min_tens, min_ones, sec_tens, sec_ones, paused, blank_min, blank_sec,
               e_min, e_sec, e_p, e_bm, e_bs);
    end
  endtask

  // One clock: drive inputs, update model at the edge, compare 1 ns later.
  task automatic step(input string name, input logic [7:0] v);
    @(negedge clk);
    {rst, tick_1hz, tick_2hz, tick_blink, adj, sel, pause_p, clr_p} = v;
    @(posedge clk);
    model_update(v);
    #1;
    $display("%0t %s in=%b -> %0h%0h:%0h%0h p=%0b bm=%0b bs=%0b", $time, name, v,
             min_tens, min_ones, sec_tens, sec_ones, paused, blank_min, blank_sec);
    check({name, "/model"}, m_min, m_sec, m_paused, m_bmin, m_bsec);
  endtask

  // Reach mm:ss through adjust mode, then leave RUN-ready (not paused, adj=0).
  task automatic preload(input int mm, input int ss);
    step("pre_clr", 8'b0000_1001);
    for (int i = 0; i < mm; i++) step("pre_min", 8'b0010_1000);
    for (int i = 0; i < ss; i++) step("pre_sec", 8'b0010_1100);
    if (m_paused) step("pre_unpause", 8'b0000_1010);
    step("pre_exit", 8'b0000_0000);
  endtask

  logic       adj_r = 1'b0;
  logic       sel_r = 1'b0;
  logic [7:0] rv;

  initial begin
    //                  rst t1 t2 tb adj sel pp clr   mm  ss  {p,bm,bs}
    vecs.push_back(vec_t'{8'b1000_0000,  0,  0, 3'b100});  // reset
    vecs.push_back(vec_t'{8'b0100_0000,  0,  0, 3'b100});  // paused: ticks ignored
    vecs.push_back(vec_t'{8'b0100_0000,  0,  0, 3'b100});
    vecs.push_back(vec_t'{8'b0100_0000,  0,  0, 3'b100});
    vecs.push_back(vec_t'{8'b0000_0010,  0,  0, 3'b000});  // unpause
    vecs.push_back(vec_t'{8'b0100_0000,  0,  1, 3'b000});
    vecs.push_back(vec_t'{8'b0100_0000,  0,  2, 3'b000});
    vecs.push_back(vec_t'{8'b0100_0000,  0,  3, 3'b000});
    vecs.push_back(vec_t'{8'b0100_0000,  0,  4, 3'b000});
    vecs.push_back(vec_t'{8'b0100_0000,  0,  5, 3'b000});
    vecs.push_back(vec_t'{8'b0100_0010,  0,  6, 3'b100});  // pause with tick: tick counts
    vecs.push_back(vec_t'{8'b0100_0000,  0,  6, 3'b100});  // now held
    vecs.push_back(vec_t'{8'b0001_1000,  0,  6, 3'b110});  // blink min on
    vecs.push_back(vec_t'{8'b0001_1000,  0,  6, 3'b100});  // blink min off
    vecs.push_back(vec_t'{8'b0001_1000,  0,  6, 3'b110});
    vecs.push_back(vec_t'{8'b0000_1100,  0,  6, 3'b101});  // sel flips: seconds blank
    vecs.push_back(vec_t'{8'b0000_0000,  0,  6, 3'b100});  // adj off clears phase
    vecs.push_back(vec_t'{8'b0100_1000,  0,  6, 3'b100});  // ADJ ignores 1 Hz
    vecs.push_back(vec_t'{8'b0010_1000,  1,  6, 3'b100});  // adjust minutes
    vecs.push_back(vec_t'{8'b0010_1100,  1,  7, 3'b100});  // adjust seconds
    vecs.push_back(vec_t'{8'b0000_1010,  1,  7, 3'b000});  // pause toggles in ADJ
    vecs.push_back(vec_t'{8'b0100_0000,  1,  8, 3'b000});  // RUN
    vecs.push_back(vec_t'{8'b0100_1000,  1,  8, 3'b000});  // tick on adj rise ignored
    vecs.push_back(vec_t'{8'b0100_0000,  1,  9, 3'b000});
    vecs.push_back(vec_t'{8'b0100_0001,  0,  0, 3'b000});  // clear beats tick
    vecs.push_back(vec_t'{8'b0100_0000,  0,  1, 3'b000});
    vecs.push_back(vec_t'{8'b1100_0000,  0,  0, 3'b100});  // reset mid-count

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].e_min, vecs[i].e_sec,
            vecs[i].e_f[2], vecs[i].e_f[1], vecs[i].e_f[0]);
    end

    // Minute carry across a tens boundary.
    preload(9, 59);
    step("run_09_59", 8'b0100_0000);
    check("carry_09_59_to_10_00", 10, 0, 1'b0, 1'b0, 1'b0);

    // Full wrap 59:59 -> 00:00.
    preload(59, 59);
    step("run_59_59", 8'b0100_0000);
    check("wrap_59_59_to_00_00", 0, 0, 1'b0, 1'b0, 1'b0);

    // Seconds adjust wrap, no carry into minutes, 1 Hz ignored.
    preload(7, 58);
    step("adj_sec", 8'b0010_1100);
    check("adj_sec_59", 7, 59, 1'b0, 1'b0, 1'b0);
    step("adj_sec", 8'b0010_1100);
    check("adj_sec_wrap_00", 7, 0, 1'b0, 1'b0, 1'b0);
    step("adj_sec_t1", 8'b0110_1100);
    check("adj_sec_01_t1_ignored", 7, 1, 1'b0, 1'b0, 1'b0);

    // Minutes adjust wrap, seconds untouched.
    preload(59, 30);
    step("adj_min", 8'b0010_1000);
    check("adj_min_wrap", 0, 30, 1'b0, 1'b0, 1'b0);

    // Clear with tick at 12:34; then clear while paused keeps paused.
    preload(12, 34);
    step("clr_t1", 8'b0100_0001);
    check("clr_beats_tick", 0, 0, 1'b0, 1'b0, 1'b0);
    step("pause", 8'b0000_0010);
    step("clr_paused", 8'b0000_0001);
    check("clr_keeps_paused", 0, 0, 1'b1, 1'b0, 1'b0);

    // Randomized run against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) adj_r = ~adj_r;
      if ($urandom_range(0, 3) == 0) sel_r = ~sel_r;
      rv    = '0;
      rv[7] = ($urandom_range(0, 149) == 0);
      rv[6] = ($urandom_range(0, 1) == 1);
      rv[5] = ($urandom_range(0, 1) == 1);
      rv[4] = ($urandom_range(0, 2) == 0);
      rv[3] = adj_r;
      rv[2] = sel_r;
      rv[1] = ($urandom_range(0, 15) == 0);
      rv[0] = ($urandom_range(0, 39) == 0);
      step("rand", rv);
    end

    step("idle", 8'b0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
